// File: rtl/pointer_scan_ctrl_pkg.sv
// pointer_scan_ctrl_pkg
// Purpose : shared types and default widths for the pointer scan controller
//           slice (top, interface and counter sub-module).
// Contents: AW_DEF / CW_DEF default widths, FSM state enum, per-pointer
//           strobe bundle.
package pointer_scan_ctrl_pkg;

  localparam int AW_DEF = 8;  // pointer / write-bus width
  localparam int CW_DEF = 8;  // width of the row/column counts

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_LDR   = 3'd2,
    ST_LDC   = 3'd3,
    ST_ISSUE = 3'd4,
    ST_STEP  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Strobes driven to one pointer register; at most one bit is set per cycle.
  typedef struct packed {
    logic wen;
    logic restore;
    logic inc;
  } ptr_strobe_t;

endpackage

// File: rtl/pointer_scan_ctrl_if.sv
// pointer_scan_ctrl_if
// Purpose : bundles the control-side request (start, bases, counts), the
//           downstream element handshake and the pointer-register write bus
//           and strobes of the pointer scan controller.
// Modports: master - the controller (drives busy/elem_valid/done/bus/strobes)
//           slave  - the environment (drives start/bases/counts/elem_ack)
import pointer_scan_ctrl_pkg::*;

interface pointer_scan_ctrl_if #(
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) ();

  logic          start;
  logic [AW-1:0] row_base;
  logic [AW-1:0] col_base;
  logic [CW-1:0] n_rows;
  logic [CW-1:0] n_cols;
  logic          elem_ack;
  logic          busy;
  logic          elem_valid;
  logic          done;
  logic [AW-1:0] bus_out;
  logic          rp_wen;
  logic          rp_restore;
  logic          rp_inc;
  logic          cp_wen;
  logic          cp_restore;
  logic          cp_inc;

  modport master (
    input  start, row_base, col_base, n_rows, n_cols, elem_ack,
    output busy, elem_valid, done, bus_out,
    output rp_wen, rp_restore, rp_inc, cp_wen, cp_restore, cp_inc
  );

  modport slave (
    output start, row_base, col_base, n_rows, n_cols, elem_ack,
    input  busy, elem_valid, done, bus_out,
    input  rp_wen, rp_restore, rp_inc, cp_wen, cp_restore, cp_inc
  );

endinterface

// File: rtl/pointer_scan_ctrl_scan_counter2d.sv
// scan_counter2d
// Purpose : row/column position counters of a row-major scan plus the
//           "last column" and "last element" compare flags.
// Ports   : Clk, RST (sync, active-high)
//           clr         - zero both counters (scan accepted)
//           step        - advance one element in row-major order
//           n_rows/n_cols - captured scan bounds (non-zero while stepping)
//           last_col_s  - column counter sits on the final column
//           last_elem_s - final column of the final row
import pointer_scan_ctrl_pkg::*;

module scan_counter2d #(
  parameter int CW = CW_DEF
) (
  input  logic          Clk,
  input  logic          RST,
  input  logic          clr,
  input  logic          step,
  input  logic [CW-1:0] n_rows,
  input  logic [CW-1:0] n_cols,
  output logic          last_col_s,
  output logic          last_elem_s
);

  logic [CW-1:0] row_cnt_r;
  logic [CW-1:0] col_cnt_r;
  logic [CW-1:0] row_max_s;
  logic [CW-1:0] col_max_s;

  // Compare flags; n-1 is taken in CW bits so a count of 255 stays exact.
  always_comb begin
    row_max_s   = n_rows - CW'(1);
    col_max_s   = n_cols - CW'(1);
    last_col_s  = (col_cnt_r == col_max_s);
    last_elem_s = last_col_s && (row_cnt_r == row_max_s);
  end

  // Row/column counters: column wraps to 0 and carries into the row.
  always_ff @(posedge Clk) begin
    if (RST) begin
      row_cnt_r <= {CW{1'b0}};
      col_cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      row_cnt_r <= {CW{1'b0}};
      col_cnt_r <= {CW{1'b0}};
    end else if (step) begin
      if (last_col_s) begin
        col_cnt_r <= {CW{1'b0}};
        row_cnt_r <= row_cnt_r + CW'(1);
      end else begin
        col_cnt_r <= col_cnt_r + CW'(1);
        row_cnt_r <= row_cnt_r;
      end
    end else begin
      row_cnt_r <= row_cnt_r;
      col_cnt_r <= col_cnt_r;
    end
  end

endmodule

// File: rtl/pointer_scan_ctrl.sv
// pointer_scan_ctrl
// Purpose : sequences a row pointer and a column pointer register through an
//           n_rows x n_cols region in row-major order, presenting one element
//           per elem_valid/elem_ack handshake.
// Ports   : Clk  - system clock, rising edge
//           RST  - synchronous, active-high reset
//           scan - pointer_scan_ctrl_if.master: start/bases/counts/elem_ack in,
//                  busy/elem_valid/done, shared bus_out and rp_*/cp_* strobes out
// The pointer registers only latch their restore base when written while
// holding 0, so each scan first clears both pointers and then loads the bases.
import pointer_scan_ctrl_pkg::*;

module pointer_scan_ctrl #(
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                 Clk,
  input  logic                 RST,
  pointer_scan_ctrl_if.master  scan
);

  state_t        state_r;
  state_t        next_state_s;
  logic          accept_s;
  logic          empty_s;
  logic          last_col_s;
  logic          last_elem_s;

  logic [AW-1:0] row_base_r;
  logic [AW-1:0] col_base_r;
  logic [CW-1:0] n_rows_r;
  logic [CW-1:0] n_cols_r;

  logic          busy_s,  busy_r;
  logic          valid_s, valid_r;
  logic          done_s,  done_r;
  logic [AW-1:0] bus_s,   bus_r;
  ptr_strobe_t   rp_s,    rp_r;
  ptr_strobe_t   cp_s,    cp_r;

  assign accept_s = (state_r == ST_IDLE) && scan.start;
  assign empty_s  = (scan.n_rows == {CW{1'b0}}) || (scan.n_cols == {CW{1'b0}});

  scan_counter2d #(.CW(CW)) u_cnt (
    .Clk         (Clk),
    .RST         (RST),
    .clr         (accept_s),
    .step        (state_r == ST_STEP),
    .n_rows      (n_rows_r),
    .n_cols      (n_cols_r),
    .last_col_s  (last_col_s),
    .last_elem_s (last_elem_s)
  );

  // Capture scan bases and bounds when a start is accepted.
  always_ff @(posedge Clk) begin
    if (RST) begin
      row_base_r <= {AW{1'b0}};
      col_base_r <= {AW{1'b0}};
      n_rows_r   <= {CW{1'b0}};
      n_cols_r   <= {CW{1'b0}};
    end else if (accept_s) begin
      row_base_r <= scan.row_base;
      col_base_r <= scan.col_base;
      n_rows_r   <= scan.n_rows;
      n_cols_r   <= scan.n_cols;
    end else begin
      row_base_r <= row_base_r;
      col_base_r <= col_base_r;
      n_rows_r   <= n_rows_r;
      n_cols_r   <= n_cols_r;
    end
  end

  // State register plus registered Moore outputs of the state being entered.
  always_ff @(posedge Clk) begin
    if (RST) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      bus_r   <= {AW{1'b0}};
      rp_r    <= '{wen: 1'b0, restore: 1'b0, inc: 1'b0};
      cp_r    <= '{wen: 1'b0, restore: 1'b0, inc: 1'b0};
    end else begin
      state_r <= next_state_s;
      busy_r  <= busy_s;
      valid_r <= valid_s;
      done_r  <= done_s;
      bus_r   <= bus_s;
      rp_r    <= rp_s;
      cp_r    <= cp_s;
    end
  end

  // Next-state logic; an empty region skips straight to DONE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (scan.start) begin
          if (empty_s) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_CLR;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CLR:   next_state_s = ST_LDR;
      ST_LDR:   next_state_s = ST_LDC;
      ST_LDC:   next_state_s = ST_ISSUE;
      ST_ISSUE: begin
        if (scan.elem_ack) begin
          if (last_elem_s) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_STEP;
          end
        end else begin
          next_state_s = ST_ISSUE;
        end
      end
      ST_STEP:  next_state_s = ST_ISSUE;
      ST_DONE:  next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Output decode of the next state; the counters still hold the ISSUE
  // position while STEP is being decoded, so last_col_s picks the move.
  always_comb begin
    busy_s  = (next_state_s != ST_IDLE);
    valid_s = 1'b0;
    done_s  = 1'b0;
    bus_s   = {AW{1'b0}};
    rp_s    = '{wen: 1'b0, restore: 1'b0, inc: 1'b0};
    cp_s    = '{wen: 1'b0, restore: 1'b0, inc: 1'b0};
    case (next_state_s)
      ST_CLR: begin
        rp_s.wen = 1'b1;
        cp_s.wen = 1'b1;
      end
      ST_LDR: begin
        bus_s    = row_base_r;
        rp_s.wen = 1'b1;
      end
      ST_LDC: begin
        bus_s    = col_base_r;
        cp_s.wen = 1'b1;
      end
      ST_ISSUE: valid_s = 1'b1;
      ST_STEP: begin
        if (last_col_s) begin
          cp_s.restore = 1'b1;
          rp_s.inc     = 1'b1;
        end else begin
          cp_s.inc = 1'b1;
        end
      end
      ST_DONE: done_s = 1'b1;
      ST_IDLE: done_s = 1'b0;
      default: done_s = 1'b0;
    endcase
  end

  assign scan.busy       = busy_r;
  assign scan.elem_valid = valid_r;
  assign scan.done       = done_r;
  assign scan.bus_out    = bus_r;
  assign scan.rp_wen     = rp_r.wen;
  assign scan.rp_restore = rp_r.restore;
  assign scan.rp_inc     = rp_r.inc;
  assign scan.cp_wen     = cp_r.wen;
  assign scan.cp_restore = cp_r.restore;
  assign scan.cp_inc     = cp_r.inc;

endmodule

// File: tb/tb_pointer_scan_ctrl.sv
// tb_pointer_scan_ctrl
// Self-checking bench: a behavioural pointer-register pair driven by the DUT
// strobes, an expected-element queue built from plain row-major loops, one
// per-cycle compare process, and directed scenarios with literal expectations.
module tb_pointer_scan_ctrl;

  logic Clk = 1'b0;
  logic RST = 1'b1;
  always #5 Clk = ~Clk;

  pointer_scan_ctrl_if #(.AW(8), .CW(8)) sif ();
  pointer_scan_ctrl #(.AW(8), .CW(8)) dut (.Clk(Clk), .RST(RST), .scan(sif));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_count = 0;
  int valid_cycles = 0;
  int done_count = 0;
  int strobe_cycles = 0;
  logic preset_req = 1'b0;

  // Pointer register model: value plus restore base latched on write-at-zero.
  logic [7:0] rp_val = 8'h00, rp_base = 8'h00, cp_val = 8'h00, cp_base = 8'h00;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  // Per-cycle compare against the model, then apply this cycle's strobes.
  always @(negedge Clk) begin
    int nrs, ncs;
    nrs = int'(sif.rp_wen) + int'(sif.rp_restore) + int'(sif.rp_inc);
    ncs = int'(sif.cp_wen) + int'(sif.cp_restore) + int'(sif.cp_inc);
    chk("rp_strobe_excl", nrs <= 1, 1);
    chk("cp_strobe_excl", ncs <= 1, 1);
    if (nrs + ncs > 0) strobe_cycles++;
    if (sif.done) done_count++;
    if (sif.elem_valid) begin
      valid_cycles++;
      if (exp_q.size() == 0) begin
        chk("elem_extra", 1, 0);
      end else begin
        chk("elem_addr", {rp_val, cp_val}, exp_q[0]);
        if (sif.elem_ack) begin
          void'(exp_q.pop_front());
          hs_count++;
        end
      end
    end
    if (preset_req) begin
      rp_val = 8'h55; cp_val = 8'h55; rp_base = 8'hAA; cp_base = 8'hAA;
    end else begin
      if (sif.rp_wen) begin
        if (rp_val == 8'h00) rp_base = sif.bus_out;
        rp_val = sif.bus_out;
      end else if (sif.rp_restore) rp_val = rp_base;
      else if (sif.rp_inc) rp_val = rp_val + 8'd1;
      if (sif.cp_wen) begin
        if (cp_val == 8'h00) cp_base = sif.bus_out;
        cp_val = sif.bus_out;
      end else if (sif.cp_restore) cp_val = cp_base;
      else if (sif.cp_inc) cp_val = cp_val + 8'd1;
    end
  end

  // Queue the expected addresses, pulse start, then scramble the inputs.
  task automatic start_scan(input logic [7:0] rb, input logic [7:0] cb,
                            input int nr, input int nc);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++)
        exp_q.push_back({8'(int'(rb) + r), 8'(int'(cb) + c)});
    sif.row_base = rb; sif.col_base = cb;
    sif.n_rows = 8'(nr); sif.n_cols = 8'(nc);
    sif.start = 1'b1;
    cyc = 0;
    tick();
    sif.start = 1'b0;
    sif.row_base = 8'hEE; sif.col_base = 8'hDD; sif.n_rows = 8'd7; sif.n_cols = 8'd9;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    int g = 0;
    while (!sif.done && g < budget) begin
      tick();
      g++;
    end
    chk("done_seen", sif.done, 1);
    dcyc = cyc;
  endtask

  initial begin
    int h0, v0, d0, s0, dc;
    sif.start = 1'b0; sif.elem_ack = 1'b0;
    sif.row_base = 8'h00; sif.col_base = 8'h00; sif.n_rows = 8'd0; sif.n_cols = 8'd0;

    // Reset state
    tick(); tick(); tick();
    chk("reset_outs", {sif.busy, sif.elem_valid, sif.done, sif.bus_out,
                       sif.rp_wen, sif.rp_restore, sif.rp_inc,
                       sif.cp_wen, sif.cp_restore, sif.cp_inc}, 0);
    RST = 1'b0;
    tick();

    // 2x3 scan, ack always high: load sequence, latency and throughput
    sif.elem_ack = 1'b1;
    h0 = hs_count; v0 = valid_cycles; d0 = done_count;
    start_scan(8'h10, 8'h20, 2, 3);
    chk("t1_clr", {sif.busy, sif.rp_wen, sif.cp_wen, sif.bus_out}, {3'b111, 8'h00});
    tick();
    chk("t1_ldr", {sif.rp_wen, sif.cp_wen, sif.bus_out}, {2'b10, 8'h10});
    tick();
    chk("t1_ldc", {sif.rp_wen, sif.cp_wen, sif.bus_out}, {2'b01, 8'h20});
    tick();
    chk("t1_first_valid", sif.elem_valid, 1);
    wait_done(40, dc);
    chk("t1_done_cycle", dc, 15);
    tick();
    chk("t1_after_done", {sif.busy, sif.done}, 0);
    chk("t1_handshakes", hs_count - h0, 6);
    chk("t1_valid_cycles", valid_cycles - v0, 6);
    chk("t1_done_pulses", done_count - d0, 1);
    chk("t1_queue_empty", exp_q.size(), 0);
    chk("t1_final_ptrs", {rp_val, cp_val}, 16'h1122);
    chk("t1_bases", {rp_base, cp_base}, 16'h1020);

    // Base latch: pointers preset to 0x55 must still take the new bases
    preset_req = 1'b1;
    tick();
    preset_req = 1'b0;
    chk("t2_preset", {rp_val, rp_base}, 16'h55AA);
    h0 = hs_count;
    start_scan(8'h30, 8'h40, 2, 2);
    tick();
    chk("t2_after_clr", {rp_val, rp_base}, 16'h00AA);
    tick();
    chk("t2_row_base", {rp_val, rp_base}, 16'h3030);
    wait_done(40, dc);
    chk("t2_done_cycle", dc, 11);
    chk("t2_col_base", cp_base, 8'h40);
    chk("t2_final_ptrs", {rp_val, cp_val}, 16'h3141);
    chk("t2_handshakes", hs_count - h0, 4);
    tick();

    // Empty region: no strobes, done in the first cycle after start
    h0 = hs_count; v0 = valid_cycles; s0 = strobe_cycles;
    start_scan(8'h01, 8'h02, 0, 5);
    chk("t3_busy_done", {sif.busy, sif.done}, 2'b11);
    tick();
    chk("t3_after", {sif.busy, sif.done}, 2'b00);
    chk("t3_no_strobes", strobe_cycles - s0, 0);
    chk("t3_no_elems", (hs_count - h0) + (valid_cycles - v0), 0);
    tick();

    // 1x1 scan with ack held low: stable element, then done after ack
    sif.elem_ack = 1'b0;
    h0 = hs_count;
    start_scan(8'h70, 8'h80, 1, 1);
    tick(); tick(); tick();
    s0 = strobe_cycles;
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", sif.elem_valid, 1);
      chk("t4_hold_ptrs", {rp_val, cp_val}, 16'h7080);
      tick();
    end
    sif.elem_ack = 1'b1;
    tick();
    sif.elem_ack = 1'b0;
    chk("t4_done_next", {sif.done, sif.elem_valid}, 2'b10);
    chk("t4_no_strobes", strobe_cycles - s0, 0);
    chk("t4_handshakes", hs_count - h0, 1);
    tick();

    // Reset during STEP of a 3x3 wrapping scan, then a clean 2x2 scan
    sif.elem_ack = 1'b1;
    start_scan(8'hF0, 8'hFE, 3, 3);
    tick(); tick(); tick(); tick();
    chk("t5_in_step", {sif.cp_inc, sif.elem_valid}, 2'b10);
    RST = 1'b1;
    tick();
    chk("t5_reset_outs", {sif.busy, sif.elem_valid, sif.done, sif.bus_out,
                          sif.rp_wen, sif.rp_restore, sif.rp_inc,
                          sif.cp_wen, sif.cp_restore, sif.cp_inc}, 0);
    RST = 1'b0;
    exp_q.delete();
    tick();
    h0 = hs_count;
    start_scan(8'hFF, 8'h10, 2, 2);
    wait_done(40, dc);
    chk("t5_done_cycle", dc, 11);
    chk("t5_handshakes", hs_count - h0, 4);
    chk("t5_final_ptrs", {rp_val, cp_val}, 16'h0011);
    chk("t5_queue_empty", exp_q.size(), 0);
    tick();

    // start during ISSUE with other bounds is ignored
    sif.elem_ack = 1'b0;
    h0 = hs_count;
    start_scan(8'h20, 8'h30, 2, 2);
    tick(); tick(); tick();
    sif.row_base = 8'h99; sif.col_base = 8'h99; sif.n_rows = 8'd5; sif.n_cols = 8'd5;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    sif.elem_ack = 1'b1;
    wait_done(60, dc);
    chk("t6_done_cycle", dc, 12);
    chk("t6_handshakes", hs_count - h0, 4);
    chk("t6_queue_empty", exp_q.size(), 0);
    tick();
    chk("t6_idle", {sif.busy, sif.done}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
